// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for the immediate-extension pipeline: input side,
// output side, flush and occupancy status. The unit is the slave; the
// decode stage driving it is the master.
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] ext;
  logic             busy;

  modport master (
    output flush, in_valid, imm, mode, out_ready,
    input  in_ready, out_valid, ext, busy
  );

  modport slave (
    input  flush, in_valid, imm, mode, out_ready,
    output in_ready, out_valid, ext, busy
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit: SEXT / ZEXT / UPPER / BOFF computed
// combinationally at the input, then carried through STAGES elastic
// register stages with valid/ready flow control and a synchronous flush.
module imm_ext_pipe #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 1
) (
  input logic           clk,
  input logic           resetn,
  imm_ext_pipe_if.slave bus
);

  localparam logic [1:0] MODE_SEXT  = 2'b00;
  localparam logic [1:0] MODE_ZEXT  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;

  if (IN_W < 2 || OUT_W < IN_W + 2 || STAGES < 1 || STAGES > 4) begin : g_bad_params
    $error("imm_ext_pipe: illegal IN_W/OUT_W/STAGES combination");
  end

  logic [OUT_W-1:0]  sext_val;
  logic [OUT_W-1:0]  new_val;
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] stage_open;
  logic [OUT_W-1:0]  data [STAGES];

  // Mode arithmetic on the raw immediate, feeding stage 0 only.
  always_comb begin
    sext_val = {{(OUT_W-IN_W){bus.imm[IN_W-1]}}, bus.imm};
    case (bus.mode)
      MODE_SEXT:  new_val = sext_val;
      MODE_ZEXT:  new_val = {{(OUT_W-IN_W){1'b0}}, bus.imm};
      MODE_UPPER: new_val = {bus.imm, {(OUT_W-IN_W){1'b0}}};
      default:    new_val = {sext_val[OUT_W-3:0], 2'b00};
    endcase
  end

  // The recursive "open" rule flattens to: some stage at or after k is
  // empty, or the consumer is taking the output.
  for (genvar g = 0; g < STAGES; g++) begin : g_open
    assign stage_open[g] = !(&valid[STAGES-1:g]) || bus.out_ready;
  end

  // Stage registers: open stages shift forward, flush empties all valids.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        data[k] <= '0;
      end
    end else begin
      if (stage_open[0]) begin
        valid[0] <= bus.in_valid;
        data[0]  <= new_val;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (stage_open[k]) begin
          valid[k] <= valid[k-1];
          data[k]  <= data[k-1];
        end
      end
      if (bus.flush) begin
        valid <= '0;
      end
    end
  end

  assign bus.in_ready  = stage_open[0];
  assign bus.out_valid = valid[STAGES-1];
  assign bus.ext       = data[STAGES-1];
  assign bus.busy      = |valid;

endmodule
